// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first.
//
// Oversamples the line on a clken strobe running at OVERSAMPLE x baud. Each bit is decided by a
// 3-sample majority vote taken around mid-bit. A received byte is held on dout_o with a
// rdy_o / rdy_clr_i handshake. Overrun and framing errors are reported to the consumer.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
// Without it, parity_err_o is tied low.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   clken_i       one-clk strobe at OVERSAMPLE x baud
//   rx_i          asynchronous serial line, idle high
//   rdy_clr_i     consumer acknowledge; clears rdy_o and overrun_o
//   dout_o        last good received byte
//   rdy_o         dout_o holds an unread byte
//   overrun_o     sticky; a byte completed while rdy_o was set
//   frame_err_o   one-clk pulse; stop bit voted low
//   parity_err_o  one-clk pulse; parity mismatch (parity build only)
//   busy_o        receiver is not idle
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,  // power of two, >= 8
  parameter int unsigned SYNC_STAGES = 2    // >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken_i,
  input  logic       rx_i,
  input  logic       rdy_clr_i,
  output logic [7:0] dout_o,
  output logic       rdy_o,
  output logic       overrun_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int unsigned ScW  = $clog2(OVERSAMPLE);
  localparam int unsigned Half = OVERSAMPLE / 2;

  localparam logic [ScW-1:0] TickVoteA = ScW'(Half - 1);
  localparam logic [ScW-1:0] TickVoteB = ScW'(Half);
  localparam logic [ScW-1:0] TickDec   = ScW'(Half + 1);
  localparam logic [ScW-1:0] TickEnd   = ScW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [ScW-1:0]         sc_q, sc_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             vote_q, vote_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             dout_q, dout_d;
  logic                   rdy_q, rdy_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic rxs;
  logic tick_va, tick_vb, tick_dec, tick_end;
  logic maj;
  logic stop_dec, shift_en;
  logic frame_bad, par_bad, byte_ok;

  assign rxs = sync_q[SYNC_STAGES-1];

  assign tick_va  = clken_i && (sc_q == TickVoteA);
  assign tick_vb  = clken_i && (sc_q == TickVoteB);
  assign tick_dec = clken_i && (sc_q == TickDec);
  assign tick_end = clken_i && (sc_q == TickEnd);

  // Majority of the two stored votes and the live third sample; only meaningful on tick_dec.
  assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clken_i && !rxs) state_d = StStart;
      end
      StStart: begin
        // A start bit that votes high was a glitch; drop back silently.
        if (tick_dec && maj) begin
          state_d = StIdle;
        end else if (tick_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick_end && (bit_cnt_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: begin
        if (tick_end) state_d = StStop;
      end
      StStop: begin
        // Leave at mid stop bit so a slightly fast transmitter's next start edge is not missed.
        if (tick_dec) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs and decoded strobes
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    busy_o   = (state_q != StIdle);
    stop_dec = (state_q == StStop) && tick_dec;
    shift_en = (state_q == StData) && tick_dec;
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;

  // Even parity: the parity bit must equal the XOR of the data bits.
  assign par_bad = stop_dec && (par_q != (^shift_q));

  always_comb begin
    par_d        = par_q;
    parity_err_d = par_bad;
    if ((state_q == StParity) && tick_dec) par_d = maj;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  assign frame_bad = stop_dec && !maj;
  assign byte_ok   = stop_dec && maj && !par_bad;

  // ---------------------------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_i};
    sc_d        = sc_q;
    bit_cnt_d   = bit_cnt_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    rdy_d       = rdy_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_bad;

    if (clken_i) begin
      if (state_q == StIdle) begin
        // The detecting tick counts as tick 0 of the start bit.
        sc_d = rxs ? '0 : ScW'(1);
      end else if (state_d == StIdle) begin
        sc_d = '0;
      end else begin
        sc_d = sc_q + 1'b1;
      end
    end

    if ((state_q == StStart) && (state_d == StData)) begin
      bit_cnt_d = 3'd0;
    end else if ((state_q == StData) && tick_end && (bit_cnt_q != 3'd7)) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (tick_va) vote_d[0] = rxs;
    if (tick_vb) vote_d[1] = rxs;

    // Right shift with the new bit at the MSB yields LSB-first ordering after eight bits.
    if (shift_en) shift_d = {maj, shift_q[7:1]};

    // A completion in the same cycle as an acknowledge takes priority over the clear.
    if (byte_ok) begin
      if (!rdy_q || rdy_clr_i) begin
        dout_d = shift_q;
        rdy_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rdy_clr_i) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      sc_q        <= '0;
      bit_cnt_q   <= 3'd0;
      vote_q      <= 2'b00;
      shift_q     <= 8'h00;
      dout_q      <= 8'h00;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sc_q        <= sc_d;
      bit_cnt_q   <= bit_cnt_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      rdy_q       <= rdy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dout_o      = dout_q;
  assign rdy_o       = rdy_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned Os = 16;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clken   = 1'b0;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy, overrun, frame_err, parity_err, busy;

  int n_vec  = 0;
  int n_err  = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] sb_q[$];

  uart_receiver #(
    .OVERSAMPLE (Os),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clken_i     (clken),
    .rx_i        (rx),
    .rdy_clr_i   (rdy_clr),
    .dout_o      (dout),
    .rdy_o       (rdy),
    .overrun_o   (overrun),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // clken: one clk high every four clks.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      clken = 1'b1;
      @(negedge clk);
      clken = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every rising rdy, count error pulses.
  initial begin
    logic       rdy_prev;
    logic [7:0] exp;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (rdy && !rdy_prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: rdy rose with dout=%02h, no byte expected", dout);
        end else begin
          exp = sb_q.pop_front();
          check("sb_dout", int'(dout), int'(exp));
        end
      end
      rdy_prev = rdy;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tx_bit(input logic b);
    rx = b;
    repeat (Os) @(posedge clken);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clken);
  endtask

  // Frame with correct parity (when parity is enabled) and the given stop bit.
  task automatic send(input logic [7:0] d, input logic stop_bit);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    tx_bit(^d);
`endif
    tx_bit(stop_bit);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_badpar(input logic [7:0] d);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
    tx_bit(~(^d));
    tx_bit(1'b1);
    rx = 1'b1;
  endtask
`endif

  task automatic ack();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int fe0;
    int busy_cyc;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dout", int'(dout), 8'h00);
    check("rst_rdy", int'(rdy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(8);

    // Good byte A5
    sb_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    idle(4);
    check("a5_received", sb_q.size(), 0);
    check("a5_rdy", int'(rdy), 1);
    check("a5_overrun", int'(overrun), 0);
    check("a5_no_frame_err", fe_cnt, 0);
    ack();
    check("a5_ack_rdy", int'(rdy), 0);

    // Overrun: 3C unread, then 7E is dropped
    sb_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    idle(4);
    send(8'h7E, 1'b1);
    idle(4);
    check("ovr_received", sb_q.size(), 0);
    check("ovr_dout_kept", int'(dout), 8'h3C);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_rdy", int'(rdy), 1);
    ack();
    check("ovr_ack_rdy", int'(rdy), 0);
    check("ovr_ack_overrun", int'(overrun), 0);

    // 3-tick low glitch on the idle line
    fe0      = fe_cnt;
    busy_cyc = 0;
    rx       = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (i == 11) rx = 1'b1;
    end
    check("glitch_busy_seen", int'(busy_cyc > 0), 1);
    check("glitch_busy_max9ticks", int'(busy_cyc <= 9 * 4), 1);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_rdy", int'(rdy), 0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);

    // Framing error on 55
    fe0 = fe_cnt;
    send(8'h55, 1'b0);
    idle(24);
    check("fe_one_pulse", fe_cnt - fe0, 1);
    check("fe_rdy", int'(rdy), 0);
    check("fe_dout_kept", int'(dout), 8'h3C);

    // Reset during data bit 4 of FF, then a clean 12
    fe0 = fe_cnt;
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (Os + 4 * Os + 8) @(posedge clken);
        rst_n = 1'b0;
      end
    join
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dout", int'(dout), 8'h00);
    rst_n = 1'b1;
    idle(4);
    sb_q.push_back(8'h12);
    send(8'h12, 1'b1);
    idle(4);
    check("r12_received", sb_q.size(), 0);
    check("r12_dout", int'(dout), 8'h12);
    check("r12_no_frame_err", fe_cnt - fe0, 0);
    check("r12_overrun", int'(overrun), 0);
    ack();

`ifdef UART_RX_PARITY_EN
    // Parity: 01 with parity bit 0 is bad, with parity bit 1 is good
    fe0 = fe_cnt;
    send_badpar(8'h01);
    idle(4);
    check("par_bad_pulse", pe_cnt, 1);
    check("par_bad_rdy", int'(rdy), 0);
    check("par_bad_no_fe", fe_cnt - fe0, 0);
    sb_q.push_back(8'h01);
    send(8'h01, 1'b1);
    idle(4);
    check("par_good_received", sb_q.size(), 0);
    check("par_good_dout", int'(dout), 8'h01);
    check("par_good_no_pe", pe_cnt, 1);
`else
    check("no_parity_err", pe_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
